pcm_fifo_feeder: RTL and testbench

- Streaming fill controller for the PCM audio FIFO.
- Fetches 32-bit words from video memory with a req/ack handshake and unpacks them little-endian into bytes.
- Arbitrates the single FIFO write port between the host data register (AUDIO_DATA writes) and the fetch engine.
- Sits between the bus/memory arbiter and the pcm block's fifo_wrdata/fifo_write/fifo_full/fifo_almost_empty interface.

---
 rtl/pcm_fifo_feeder.sv | 269 ++++++++++++++++++++++++++
 tb/tb_pcm_fifo_feeder.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcm_fifo_feeder.sv
// pcm_fifo_feeder: fills the PCM audio FIFO from video memory.
// Fetches 32-bit words over a req/ack handshake in bursts whenever the FIFO
// reports almost-empty, unpacks them little-endian into bytes and shares the
// single FIFO write port with host AUDIO_DATA writes (host always wins).
// Optional build macro: PCM_FEEDER_UNDERRUN_EN enables the sticky underrun flag;
// without it underrun is tied low and underrun_clr is ignored.
module pcm_fifo_feeder #(
  parameter int WADDR_WIDTH = 15,
  parameter int BURST_WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stop,
  input  logic [WADDR_WIDTH-1:0] cfg_start_addr,
  input  logic [15:0]            cfg_length,
  input  logic                   cfg_loop,
  input  logic [7:0]             host_wrdata,
  input  logic                   host_write,
  output logic [7:0]             fifo_wrdata,
  output logic                   fifo_write,
  input  logic                   fifo_full,
  input  logic                   fifo_almost_empty,
  input  logic                   fifo_empty,
  output logic                   mem_req,
  output logic [WADDR_WIDTH-1:0] mem_addr,
  input  logic                   mem_ack,
  input  logic [31:0]            mem_rddata,
  output logic                   busy,
  output logic                   done,
  output logic                   underrun,
  input  logic                   underrun_clr
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WAIT_LOW = 3'd1;
  localparam logic [2:0] S_REQ      = 3'd2;
  localparam logic [2:0] S_UNPACK   = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  localparam logic [4:0] BURST_INIT = 5'(BURST_WORDS);

  logic [2:0]             state_q, state_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   mem_req_q, mem_req_d;
  logic [WADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                   fifo_write_q, fifo_write_d;
  logic [7:0]             fifo_wrdata_q, fifo_wrdata_d;
  logic [15:0]            byte_cnt_q, byte_cnt_d;
  logic [4:0]             burst_q, burst_d;
  logic [31:0]            word_q, word_d;
  logic [1:0]             byte_idx_q, byte_idx_d;
  logic [WADDR_WIDTH-1:0] start_addr_q, start_addr_d;
  logic [15:0]            length_q, length_d;
  logic                   loop_q, loop_d;
  logic                   stop_pend_q, stop_pend_d;

  logic                   grant;
  logic [7:0]             cur_byte;
  logic [15:0]            cnt_dec;
  logic [4:0]             burst_dec;

  // Current byte of the fetched word, little-endian order.
  always_comb begin
    cur_byte = word_q[7:0];
    case (byte_idx_q)
      2'd0: cur_byte = word_q[7:0];
      2'd1: cur_byte = word_q[15:8];
      2'd2: cur_byte = word_q[23:16];
      2'd3: cur_byte = word_q[31:24];
      default: cur_byte = word_q[7:0];
    endcase
  end

  // Write-port arbitration and the fill state machine.
  always_comb begin
    state_d       = state_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    mem_req_d     = mem_req_q;
    mem_addr_d    = mem_addr_q;
    fifo_write_d  = 1'b0;
    fifo_wrdata_d = fifo_wrdata_q;
    byte_cnt_d    = byte_cnt_q;
    burst_d       = burst_q;
    word_d        = word_q;
    byte_idx_d    = byte_idx_q;
    start_addr_d  = start_addr_q;
    length_d      = length_q;
    loop_d        = loop_q;
    stop_pend_d   = stop_pend_q;
    cnt_dec       = byte_cnt_q - 16'd1;
    burst_dec     = burst_q - 5'd1;

    // The host byte is forwarded even into a full FIFO; the FIFO drops it.
    grant = !fifo_full && !host_write;
    if (host_write) begin
      fifo_write_d  = 1'b1;
      fifo_wrdata_d = host_wrdata;
    end

    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          if (cfg_length == 16'd0) begin
            done_d = 1'b1;
          end else begin
            start_addr_d = cfg_start_addr;
            length_d     = cfg_length;
            loop_d       = cfg_loop;
            mem_addr_d   = cfg_start_addr;
            byte_cnt_d   = cfg_length;
            busy_d       = 1'b1;
            state_d      = S_WAIT_LOW;
          end
        end
      end

      S_WAIT_LOW: begin
        if (stop) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (fifo_almost_empty) begin
          burst_d   = BURST_INIT;
          mem_req_d = 1'b1;
          state_d   = S_REQ;
        end
      end

      S_REQ: begin
        // A stop here must not abandon the handshake: remember it and
        // finish once the memory has acked, discarding the data.
        if (stop) stop_pend_d = 1'b1;
        if (mem_ack) begin
          mem_req_d = 1'b0;
          if (stop || stop_pend_q) begin
            stop_pend_d = 1'b0;
            busy_d      = 1'b0;
            state_d     = S_IDLE;
          end else begin
            word_d     = mem_rddata;
            byte_idx_d = 2'd0;
            state_d    = S_UNPACK;
          end
        end
      end

      S_UNPACK: begin
        if (stop) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (grant) begin
          fifo_write_d  = 1'b1;
          fifo_wrdata_d = cur_byte;
          byte_cnt_d    = cnt_dec;
          byte_idx_d    = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            mem_addr_d = mem_addr_q + 1'b1;
            burst_d    = burst_dec;
          end
          // Running out mid-word drops the rest of the word.
          if (cnt_dec == 16'd0) begin
            state_d = S_DONE;
          end else if (byte_idx_q == 2'd3) begin
            if (burst_dec != 5'd0) begin
              mem_req_d = 1'b1;
              state_d   = S_REQ;
            end else begin
              state_d = S_WAIT_LOW;
            end
          end
        end
      end

      S_DONE: begin
        if (stop) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (loop_q) begin
          mem_addr_d = start_addr_q;
          byte_cnt_d = length_q;
          state_d    = S_WAIT_LOW;
        end else begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: begin
        busy_d    = 1'b0;
        mem_req_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      fifo_write_q  <= 1'b0;
      fifo_wrdata_q <= 8'd0;
      byte_cnt_q    <= 16'd0;
      burst_q       <= 5'd0;
      word_q        <= 32'd0;
      byte_idx_q    <= 2'd0;
      start_addr_q  <= '0;
      length_q      <= 16'd0;
      loop_q        <= 1'b0;
      stop_pend_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      fifo_write_q  <= fifo_write_d;
      fifo_wrdata_q <= fifo_wrdata_d;
      byte_cnt_q    <= byte_cnt_d;
      burst_q       <= burst_d;
      word_q        <= word_d;
      byte_idx_q    <= byte_idx_d;
      start_addr_q  <= start_addr_d;
      length_q      <= length_d;
      loop_q        <= loop_d;
      stop_pend_q   <= stop_pend_d;
    end
  end

`ifdef PCM_FEEDER_UNDERRUN_EN
  logic underrun_q, underrun_d;
  logic underrun_set;

  // Sticky underrun: FIFO ran dry while we were supposed to be feeding it.
  always_comb begin
    underrun_set = busy_q && fifo_empty &&
                   ((state_q == S_WAIT_LOW) || (state_q == S_REQ) || (state_q == S_UNPACK));
    underrun_d = underrun_q;
    if (underrun_clr || start) underrun_d = 1'b0;
    if (underrun_set) underrun_d = 1'b1;
  end

  // Underrun flag register.
  always_ff @(posedge clk) begin
    if (rst) underrun_q <= 1'b0;
    else     underrun_q <= underrun_d;
  end

  assign underrun = underrun_q;
`else
  logic unused_underrun_inputs;
  assign unused_underrun_inputs = underrun_clr ^ fifo_empty;
  assign underrun = 1'b0;
`endif

  assign busy        = busy_q;
  assign done        = done_q;
  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign fifo_write  = fifo_write_q;
  assign fifo_wrdata = fifo_wrdata_q;

endmodule

// File: tb/tb_pcm_fifo_feeder.sv
// Directed testbench for pcm_fifo_feeder (default parameters: 15-bit address, burst of 4).
module tb_pcm_fifo_feeder;
  logic        clk;
  logic        rst;
  logic        start, stop;
  logic [14:0] cfg_start_addr;
  logic [15:0] cfg_length;
  logic        cfg_loop;
  logic [7:0]  host_wrdata;
  logic        host_write;
  logic [7:0]  fifo_wrdata;
  logic        fifo_write;
  logic        fifo_full, fifo_almost_empty, fifo_empty;
  logic        mem_req;
  logic [14:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rddata;
  logic        busy, done, underrun, underrun_clr;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  logic [7:0] wq[$];

  pcm_fifo_feeder dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .cfg_start_addr(cfg_start_addr), .cfg_length(cfg_length), .cfg_loop(cfg_loop),
    .host_wrdata(host_wrdata), .host_write(host_write),
    .fifo_wrdata(fifo_wrdata), .fifo_write(fifo_write),
    .fifo_full(fifo_full), .fifo_almost_empty(fifo_almost_empty), .fifo_empty(fifo_empty),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rddata(mem_rddata),
    .busy(busy), .done(done), .underrun(underrun), .underrun_clr(underrun_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every FIFO write and done pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (fifo_write === 1'b1) wq.push_back(fifo_wrdata);
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input logic [14:0] a, input logic [15:0] len, input logic lp);
    cfg_start_addr = a;
    cfg_length     = len;
    cfg_loop       = lp;
    start          = 1'b1;
    step();
    start          = 1'b0;
  endtask

  // Wait (bounded) for a request, hold off 'delay' cycles, then ack with data.
  task automatic serve(input logic [31:0] data, input int delay, output logic [14:0] addr);
    int n;
    n = 0;
    while (mem_req !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    check("req_seen", {31'd0, mem_req}, 32'd1);
    repeat (delay) step();
    addr       = mem_addr;
    mem_ack    = 1'b1;
    mem_rddata = data;
    step();
    mem_ack    = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 100) begin
      step();
      n++;
    end
    check("idle_reached", {31'd0, busy}, 32'd0);
    step();
    step();
  endtask

  initial begin
    logic [14:0] a1, a2, a3;
    int d0;

    rst = 1'b1; start = 0; stop = 0; cfg_start_addr = 0; cfg_length = 0; cfg_loop = 0;
    host_wrdata = 0; host_write = 0; fifo_full = 0; fifo_almost_empty = 1; fifo_empty = 0;
    mem_ack = 0; mem_rddata = 0; underrun_clr = 0;
    step(); step();
    rst = 1'b0;

    // Reset state
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_fifo_write", {31'd0, fifo_write}, 32'd0);
    check("rst_mem_addr", {17'd0, mem_addr}, 32'd0);
    check("rst_wrdata", {24'd0, fifo_wrdata}, 32'd0);
    check("rst_underrun", {31'd0, underrun}, 32'd0);
    $display("[TB] reset state checked");

    // Zero-length start: done pulse, stays idle
    d0 = done_cnt;
    pulse_start(15'h0, 16'd0, 1'b0);
    check("len0_done", {31'd0, done}, 32'd1);
    check("len0_busy", {31'd0, busy}, 32'd0);
    step();
    check("len0_done_gone", {31'd0, done}, 32'd0);
    $display("[TB] zero-length start checked");

    // Single word, cycle exact
    pulse_start(15'h10, 16'd4, 1'b0);
    check("sw_busy", {31'd0, busy}, 32'd1);
    check("sw_req_low", {31'd0, mem_req}, 32'd0);
    step();
    check("sw_req", {31'd0, mem_req}, 32'd1);
    check("sw_addr", {17'd0, mem_addr}, 32'h10);
    step();
    check("sw_req_hold", {31'd0, mem_req}, 32'd1);
    mem_ack = 1'b1; mem_rddata = 32'h44332211;
    step();
    mem_ack = 1'b0;
    check("sw_req_drop", {31'd0, mem_req}, 32'd0);
    step();
    check("sw_b0", {23'd0, fifo_write, fifo_wrdata}, 32'h111);
    step();
    check("sw_b1", {23'd0, fifo_write, fifo_wrdata}, 32'h122);
    step();
    check("sw_b2", {23'd0, fifo_write, fifo_wrdata}, 32'h133);
    step();
    check("sw_b3", {23'd0, fifo_write, fifo_wrdata}, 32'h144);
    step();
    check("sw_done", {31'd0, done}, 32'd1);
    check("sw_busy_end", {31'd0, busy}, 32'd0);
    check("sw_no_write", {31'd0, fifo_write}, 32'd0);
    step();
    check("sw_done_one_cycle", {31'd0, done}, 32'd0);
    $display("[TB] single word transaction checked");

    // Partial word and burst, with an ignored start while busy
    step();
    wq.delete();
    d0 = done_cnt;
    pulse_start(15'h20, 16'd6, 1'b0);
    serve(32'h04030201, 1, a1);
    pulse_start(15'h55, 16'd1, 1'b0);
    serve(32'h08070605, 0, a2);
    wait_idle();
    check("pb_addr1", {17'd0, a1}, 32'h20);
    check("pb_addr2", {17'd0, a2}, 32'h21);
    check("pb_nbytes", wq.size(), 32'd6);
    for (int i = 0; i < 6 && i < wq.size(); i++)
      check("pb_byte", {24'd0, wq[i]}, 32'(i + 1));
    check("pb_done", done_cnt - d0, 32'd1);
    check("pb_no_req", {31'd0, mem_req}, 32'd0);
    $display("[TB] partial word / burst checked");

    // Host collision and FIFO full stall
    d0 = done_cnt;
    pulse_start(15'h30, 16'd4, 1'b0);
    serve(32'h44332211, 0, a1);
    step();
    check("hc_b0", {23'd0, fifo_write, fifo_wrdata}, 32'h111);
    host_write = 1'b1; host_wrdata = 8'hAA;
    step();
    host_write = 1'b0;
    check("hc_host", {23'd0, fifo_write, fifo_wrdata}, 32'h1AA);
    step();
    check("hc_b1", {23'd0, fifo_write, fifo_wrdata}, 32'h122);
    fifo_full = 1'b1;
    step();
    check("hc_stall1", {31'd0, fifo_write}, 32'd0);
    step();
    check("hc_stall2", {31'd0, fifo_write}, 32'd0);
    host_write = 1'b1; host_wrdata = 8'h55;
    step();
    host_write = 1'b0;
    check("hc_host_full", {23'd0, fifo_write, fifo_wrdata}, 32'h155);
    fifo_full = 1'b0;
    step();
    check("hc_b2", {23'd0, fifo_write, fifo_wrdata}, 32'h133);
    step();
    check("hc_b3", {23'd0, fifo_write, fifo_wrdata}, 32'h144);
    step();
    check("hc_done", {31'd0, done}, 32'd1);
    $display("[TB] host collision / full stall checked");

    // Loop and address wrap; cfg_loop is latched at start
    step();
    d0 = done_cnt;
    cfg_start_addr = 15'h7FFF; cfg_length = 16'd8; cfg_loop = 1'b1; start = 1'b1;
    step();
    start = 1'b0; cfg_loop = 1'b0;
    serve(32'h11111111, 0, a1);
    serve(32'h22222222, 0, a2);
    serve(32'h33333333, 0, a3);
    check("lp_addr_max", {17'd0, a1}, 32'h7FFF);
    check("lp_addr_wrap", {17'd0, a2}, 32'h0);
    check("lp_addr_reload", {17'd0, a3}, 32'h7FFF);
    check("lp_busy", {31'd0, busy}, 32'd1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("lp_stop_busy", {31'd0, busy}, 32'd0);
    step(); step();
    check("lp_no_done", done_cnt - d0, 32'd0);
    $display("[TB] loop / wrap checked");

    // Stop during REQ: handshake completes, data discarded
    wq.delete();
    d0 = done_cnt;
    pulse_start(15'h40, 16'd4, 1'b0);
    step();
    check("sr_req", {31'd0, mem_req}, 32'd1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("sr_req_held", {31'd0, mem_req}, 32'd1);
      if (i < 3) step();
    end
    mem_ack = 1'b1; mem_rddata = 32'hDEADBEEF;
    step();
    mem_ack = 1'b0;
    check("sr_req_drop", {31'd0, mem_req}, 32'd0);
    check("sr_busy", {31'd0, busy}, 32'd0);
    step(); step(); step();
    check("sr_no_write", wq.size(), 32'd0);
    check("sr_no_done", done_cnt - d0, 32'd0);
    check("sr_stays_idle", {31'd0, mem_req}, 32'd0);
    $display("[TB] stop during request checked");

    // Reset mid-transfer
    pulse_start(15'h60, 16'd4, 1'b0);
    step();
    check("rm_req", {31'd0, mem_req}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rm_req_drop", {31'd0, mem_req}, 32'd0);
    check("rm_busy", {31'd0, busy}, 32'd0);
    check("rm_addr", {17'd0, mem_addr}, 32'd0);
    step(); step();
    check("rm_idle", {31'd0, mem_req}, 32'd0);
    $display("[TB] reset mid-transfer checked");

    // Underrun flag
    fifo_almost_empty = 1'b0;
    pulse_start(15'h70, 16'd4, 1'b0);
    fifo_empty = 1'b1;
    step();
`ifdef PCM_FEEDER_UNDERRUN_EN
    check("ur_set", {31'd0, underrun}, 32'd1);
    fifo_empty = 1'b0; underrun_clr = 1'b1;
    step();
    underrun_clr = 1'b0;
    check("ur_clr", {31'd0, underrun}, 32'd0);
`else
    check("ur_off", {31'd0, underrun}, 32'd0);
    fifo_empty = 1'b0; underrun_clr = 1'b1;
    step();
    underrun_clr = 1'b0;
    check("ur_off2", {31'd0, underrun}, 32'd0);
`endif
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("ur_stop", {31'd0, busy}, 32'd0);
    $display("[TB] underrun checked");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
